// File: rtl/maze_pkg.sv
// maze_pkg: direction encoding, opening-bit indices, solver states
// and heading helpers shared by the maze_solver files.
package maze_pkg;

  localparam logic [1:0] DIR_N = 2'd0;
  localparam logic [1:0] DIR_E = 2'd1;
  localparam logic [1:0] DIR_S = 2'd2;
  localparam logic [1:0] DIR_W = 2'd3;

  localparam int OPEN_N = 0;
  localparam int OPEN_E = 1;
  localparam int OPEN_S = 2;
  localparam int OPEN_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_DECIDE,
    ST_MOVE,
    ST_DONE,
    ST_FAIL
  } state_t;

  function automatic logic [1:0] turn_right(
    input logic [1:0] h
  );
    return h + 2'd1;
  endfunction

  function automatic logic [1:0] turn_left(
    input logic [1:0] h
  );
    return h + 2'd3;
  endfunction

  function automatic logic [1:0] reverse(
    input logic [1:0] h
  );
    return h + 2'd2;
  endfunction

endpackage

// File: rtl/maze_solver_if.sv
// maze_solver_if: cell read port (rd_en/rd_x/rd_y/rd_data, 1-cycle
// latency) and move stream (move_valid/move_dir/move_ready).
interface maze_solver_if #(
  parameter int COORD_W = 3
);
  logic               rd_en;
  logic [COORD_W-1:0] rd_x;
  logic [COORD_W-1:0] rd_y;
  logic [3:0]         rd_data;
  logic               move_valid;
  logic [1:0]         move_dir;
  logic               move_ready;

  modport master (
    output rd_en, rd_x, rd_y,
    output move_valid, move_dir,
    input  rd_data, move_ready
  );

  modport slave (
    input  rd_en, rd_x, rd_y,
    input  move_valid, move_dir,
    output rd_data, move_ready
  );
endinterface

// File: rtl/maze_dir_select.sv
// maze_dir_select: right-hand rule picker. Inputs: masked openings,
// heading. Outputs: dir (first open of right/straight/left/back), none_open.
module maze_dir_select
  import maze_pkg::*;
(
  input  logic [3:0] openings,
  input  logic [1:0] heading,
  output logic [1:0] dir,
  output logic       none_open
);
  logic [1:0] d_r;
  logic [1:0] d_s;
  logic [1:0] d_l;
  logic [1:0] d_b;

  assign d_r = turn_right(heading);
  assign d_s = heading;
  assign d_l = turn_left(heading);
  assign d_b = reverse(heading);

  // Several openings may be set at once, so this is a priority pick.
  always_comb begin
    dir       = heading;
    none_open = 1'b0;
    priority case (1'b1)
      openings[d_r]: dir = d_r;
      openings[d_s]: dir = d_s;
      openings[d_l]: dir = d_l;
      openings[d_b]: dir = d_b;
      default:       none_open = 1'b1;
    endcase
  end
endmodule

// File: rtl/maze_solver.sv
// maze_solver: right-hand wall follower from (0,0) to (w-1,h-1).
// Ports: clk, reset (sync, high), start, maze_width/height, bus
// (read port + move stream), pos_x/y, heading, step_count, busy,
// done, fail. Option: MAZE_SOLVER_STEP_LIMIT_EN fails after STEP_LIMIT.
module maze_solver
  import maze_pkg::*;
#(
  parameter int COORD_W    = 3,
  parameter int STEP_W     = 12,
  parameter int STEP_LIMIT = 1000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [COORD_W-1:0] maze_width,
  input  logic [COORD_W-1:0] maze_height,
  maze_solver_if.master      bus,
  output logic [COORD_W-1:0] pos_x,
  output logic [COORD_W-1:0] pos_y,
  output logic [1:0]         heading,
  output logic [STEP_W-1:0]  step_count,
  output logic               busy,
  output logic               done,
  output logic               fail
);
`ifdef MAZE_SOLVER_STEP_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif
  localparam logic [STEP_W-1:0] LIMIT_M1 =
    STEP_W'(STEP_LIMIT - 1);
  localparam logic [COORD_W-1:0] ONE = COORD_W'(1);

  state_t             state;
  logic [COORD_W-1:0] w_m1;
  logic [COORD_W-1:0] h_m1;
  logic [3:0]         open_q;
  logic [3:0]         mask;
  logic               rd_en_q;
  logic               mv_q;
  logic [1:0]         dir_q;
  logic [1:0]         sel_dir;
  logic               none_open;
  logic [COORD_W-1:0] nx;
  logic [COORD_W-1:0] ny;
  logic               at_exit;
  logic               hit_limit;
  logic [STEP_W-1:0]  step_nxt;

  assign bus.rd_en      = rd_en_q;
  assign bus.rd_x       = pos_x;
  assign bus.rd_y       = pos_y;
  assign bus.move_valid = mv_q;
  assign bus.move_dir   = dir_q;

  assign busy = (state == ST_FETCH) ||
                (state == ST_WAIT)  ||
                (state == ST_DECIDE) ||
                (state == ST_MOVE);

  // Openings that lead off the grid are never legal.
  always_comb begin
    mask = bus.rd_data;
    if (pos_y == '0)   mask[OPEN_N] = 1'b0;
    if (pos_x == '0)   mask[OPEN_W] = 1'b0;
    if (pos_x == w_m1) mask[OPEN_E] = 1'b0;
    if (pos_y == h_m1) mask[OPEN_S] = 1'b0;
  end

  maze_dir_select u_sel (
    .openings  (open_q),
    .heading   (heading),
    .dir       (sel_dir),
    .none_open (none_open)
  );

  always_comb begin
    nx = pos_x;
    ny = pos_y;
    unique case (dir_q)
      DIR_N: ny = pos_y - ONE;
      DIR_E: nx = pos_x + ONE;
      DIR_S: ny = pos_y + ONE;
      DIR_W: nx = pos_x - ONE;
    endcase
  end

  assign at_exit   = (nx == w_m1) && (ny == h_m1);
  assign hit_limit = LIMIT_EN && (step_count == LIMIT_M1);
  assign step_nxt  = (&step_count) ? step_count
                   : step_count + STEP_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      w_m1       <= '0;
      h_m1       <= '0;
      open_q     <= '0;
      rd_en_q    <= 1'b0;
      mv_q       <= 1'b0;
      dir_q      <= DIR_N;
      pos_x      <= '0;
      pos_y      <= '0;
      heading    <= DIR_E;
      step_count <= '0;
      done       <= 1'b0;
      fail       <= 1'b0;
    end else begin
      rd_en_q <= 1'b0;
      unique case (state)
        ST_IDLE, ST_DONE, ST_FAIL: begin
          if (start) begin
            pos_x      <= '0;
            pos_y      <= '0;
            heading    <= DIR_E;
            step_count <= '0;
            done       <= 1'b0;
            fail       <= 1'b0;
            w_m1       <= maze_width - ONE;
            h_m1       <= maze_height - ONE;
            if (maze_width == '0 || maze_height == '0) begin
              state <= ST_FAIL;
              fail  <= 1'b1;
            end else if (maze_width == ONE &&
                         maze_height == ONE) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state   <= ST_FETCH;
              rd_en_q <= 1'b1;
            end
          end
        end
        ST_FETCH: state <= ST_WAIT;
        ST_WAIT: begin
          open_q <= mask;
          state  <= ST_DECIDE;
        end
        ST_DECIDE: begin
          if (none_open) begin
            state <= ST_FAIL;
            fail  <= 1'b1;
          end else begin
            dir_q <= sel_dir;
            mv_q  <= 1'b1;
            state <= ST_MOVE;
          end
        end
        ST_MOVE: begin
          if (bus.move_ready) begin
            mv_q       <= 1'b0;
            pos_x      <= nx;
            pos_y      <= ny;
            heading    <= dir_q;
            step_count <= step_nxt;
            if (at_exit) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else if (hit_limit) begin
              state <= ST_FAIL;
              fail  <= 1'b1;
            end else begin
              state   <= ST_FETCH;
              rd_en_q <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_maze_solver.sv
// tb_maze_solver: directed checks of maze_solver with a cell-store
// model answering reads one cycle after rd_en.
module tb_maze_solver;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [2:0] maze_width = '0;
  logic [2:0] maze_height = '0;
  logic [2:0] pos_x;
  logic [2:0] pos_y;
  logic [1:0] heading;
  logic [11:0] step_count;
  logic       busy;
  logic       done;
  logic       fail;

  int n_chk = 0;
  int n_err = 0;
  int rd_cnt = 0;
  int mv_cnt = 0;
  logic [1:0] moves[$];
  logic [3:0] cells[0:7][0:7];

  maze_solver_if #(.COORD_W(3)) bus ();

  maze_solver #(
    .COORD_W    (3),
    .STEP_W     (12),
    .STEP_LIMIT (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .maze_width  (maze_width),
    .maze_height (maze_height),
    .bus         (bus),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
    .heading     (heading),
    .step_count  (step_count),
    .busy        (busy),
    .done        (done),
    .fail        (fail)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    bus.rd_data <= bus.rd_en ? cells[bus.rd_x][bus.rd_y] : 4'h0;
    if (bus.rd_en) rd_cnt++;
    if (bus.move_valid) mv_cnt++;
    if (!reset && bus.move_valid && bus.move_ready)
      moves.push_back(bus.move_dir);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_cells();
    for (int x = 0; x < 8; x++)
      for (int y = 0; y < 8; y++)
        cells[x][y] = 4'h0;
  endtask

  // Start pulse in cycle 0; returns sampled in cycle 1.
  task automatic launch(input int w, input int h);
    maze_width  = 3'(w);
    maze_height = 3'(h);
    moves.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_end(input string nm);
    for (int i = 0; i < 100; i++) begin
      if (done || fail) break;
      tick();
    end
    n_chk++;
    if (!(done || fail)) begin
      $display("FAIL %s timeout: done=%0b fail=%0b want end",
               nm, done, fail);
      n_err++;
    end
  endtask

  task automatic corridor();
    clear_cells();
    cells[0][0] = 4'b0010;
    cells[1][0] = 4'b1010;
    cells[2][0] = 4'b1010;
    cells[3][0] = 4'b1100;
    cells[3][1] = 4'b0101;
    cells[3][2] = 4'b0101;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_chk++;
    if ({bus.rd_en, bus.move_valid, busy, done, fail} !== 5'b0) begin
      $display("FAIL reset_flags: got %b want 00000",
               {bus.rd_en, bus.move_valid, busy, done, fail});
      n_err++;
    end
    n_chk++;
    if ({pos_x, pos_y, bus.rd_x, bus.rd_y} !== 12'h0) begin
      $display("FAIL reset_pos: got %h want 000",
               {pos_x, pos_y, bus.rd_x, bus.rd_y});
      n_err++;
    end
    n_chk++;
    if (heading !== 2'd1 || step_count !== 12'd0
        || bus.move_dir !== 2'd0) begin
      $display("FAIL reset_hdg: hdg=%0d step=%0d dir=%0d want 1 0 0",
               heading, step_count, bus.move_dir);
      n_err++;
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_one_by_one();
    int rc0;
    rc0 = rd_cnt;
    launch(1, 1);
    n_chk++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      $display("FAIL 1x1_done: done=%0b busy=%0b want 1 0",
               done, busy);
      n_err++;
    end
    n_chk++;
    if (step_count !== 12'd0) begin
      $display("FAIL 1x1_step: got %0d want 0", step_count);
      n_err++;
    end
    tick();
    tick();
    tick();
    n_chk++;
    if (rd_cnt !== rc0) begin
      $display("FAIL 1x1_noread: got %0d reads want 0", rd_cnt - rc0);
      n_err++;
    end
  endtask

  task automatic test_zero_dim();
    launch(0, 3);
    n_chk++;
    if (fail !== 1'b1 || done !== 1'b0) begin
      $display("FAIL zero_dim: fail=%0b done=%0b want 1 0", fail, done);
      n_err++;
    end
  endtask

  task automatic test_two_by_one();
    clear_cells();
    cells[0][0] = 4'b0010;
    bus.move_ready = 1'b1;
    launch(2, 1);
    n_chk++;
    if (bus.rd_en !== 1'b1 || bus.rd_x !== 3'd0 || bus.rd_y !== 3'd0) begin
      $display("FAIL 2x1_c1_rd: rd_en=%0b x=%0d y=%0d want 1 0 0",
               bus.rd_en, bus.rd_x, bus.rd_y);
      n_err++;
    end
    tick();
    n_chk++;
    if (bus.rd_en !== 1'b0 || busy !== 1'b1) begin
      $display("FAIL 2x1_c2: rd_en=%0b busy=%0b want 0 1",
               bus.rd_en, busy);
      n_err++;
    end
    tick();
    n_chk++;
    if (bus.move_valid !== 1'b0) begin
      $display("FAIL 2x1_c3_mv: got %0b want 0", bus.move_valid);
      n_err++;
    end
    tick();
    n_chk++;
    if (bus.move_valid !== 1'b1 || bus.move_dir !== 2'd1) begin
      $display("FAIL 2x1_c4_move: valid=%0b dir=%0d want 1 1",
               bus.move_valid, bus.move_dir);
      n_err++;
    end
    tick();
    n_chk++;
    if (done !== 1'b1 || pos_x !== 3'd1 || pos_y !== 3'd0
        || step_count !== 12'd1) begin
      $display("FAIL 2x1_c5_done: done=%0b pos=%0d,%0d step=%0d want 1 1,0 1",
               done, pos_x, pos_y, step_count);
      n_err++;
    end
  endtask

  task automatic test_two_by_two();
    clear_cells();
    cells[0][0] = 4'b0100;
    cells[0][1] = 4'b0010;
    bus.move_ready = 1'b1;
    launch(2, 2);
    wait_end("2x2");
    n_chk++;
    if (moves.size() !== 2) begin
      $display("FAIL 2x2_nmoves: got %0d want 2", moves.size());
      n_err++;
    end else begin
      n_chk++;
      if (moves[0] !== 2'd2 || moves[1] !== 2'd1) begin
        $display("FAIL 2x2_dirs: got %0d,%0d want 2,1",
                 moves[0], moves[1]);
        n_err++;
      end
    end
    n_chk++;
    if (done !== 1'b1 || pos_x !== 3'd1 || pos_y !== 3'd1
        || step_count !== 12'd2 || heading !== 2'd1) begin
      $display("FAIL 2x2_end: done=%0b pos=%0d,%0d step=%0d hdg=%0d want 1 1,1 2 1",
               done, pos_x, pos_y, step_count, heading);
      n_err++;
    end
  endtask

  task automatic test_offgrid_fail();
    int mv0;
    clear_cells();
    cells[0][0] = 4'b1001;
    bus.move_ready = 1'b1;
    mv0 = mv_cnt;
    launch(2, 2);
    tick();
    tick();
    n_chk++;
    if (fail !== 1'b0) begin
      $display("FAIL offgrid_c3: fail=%0b want 0", fail);
      n_err++;
    end
    tick();
    n_chk++;
    if (fail !== 1'b1 || busy !== 1'b0) begin
      $display("FAIL offgrid_c4: fail=%0b busy=%0b want 1 0", fail, busy);
      n_err++;
    end
    tick();
    tick();
    n_chk++;
    if (mv_cnt !== mv0) begin
      $display("FAIL offgrid_novalid: got %0d valid cycles want 0",
               mv_cnt - mv0);
      n_err++;
    end
  endtask

  task automatic test_backpressure();
    clear_cells();
    cells[0][0] = 4'b0010;
    bus.move_ready = 1'b0;
    launch(2, 1);
    tick();
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      n_chk++;
      if (bus.move_valid !== 1'b1 || bus.move_dir !== 2'd1
          || pos_x !== 3'd0 || step_count !== 12'd0) begin
        $display("FAIL bp_hold%0d: valid=%0b dir=%0d x=%0d step=%0d want 1 1 0 0",
                 i, bus.move_valid, bus.move_dir, pos_x, step_count);
        n_err++;
      end
      tick();
    end
    bus.move_ready = 1'b1;
    tick();
    n_chk++;
    if (step_count !== 12'd1 || done !== 1'b1 || pos_x !== 3'd1) begin
      $display("FAIL bp_accept: step=%0d done=%0b x=%0d want 1 1 1",
               step_count, done, pos_x);
      n_err++;
    end
    tick();
    tick();
    n_chk++;
    if (step_count !== 12'd1) begin
      $display("FAIL bp_single: step=%0d want 1", step_count);
      n_err++;
    end
  endtask

  task automatic test_reset_mid();
    corridor();
    bus.move_ready = 1'b1;
    launch(4, 4);
    tick();
    tick();
    tick();
    tick();
    n_chk++;
    if (bus.rd_en !== 1'b1 || pos_x !== 3'd1) begin
      $display("FAIL mid_pre: rd_en=%0b x=%0d want 1 1", bus.rd_en, pos_x);
      n_err++;
    end
    reset = 1'b1;
    tick();
    n_chk++;
    if ({bus.rd_en, bus.move_valid, busy, done, fail} !== 5'b0
        || pos_x !== 3'd0 || heading !== 2'd1
        || step_count !== 12'd0) begin
      $display("FAIL mid_reset: flags=%b x=%0d hdg=%0d step=%0d want 00000 0 1 0",
               {bus.rd_en, bus.move_valid, busy, done, fail},
               pos_x, heading, step_count);
      n_err++;
    end
    reset = 1'b0;
    tick();
    tick();
    n_chk++;
    if (busy !== 1'b0 || bus.move_valid !== 1'b0) begin
      $display("FAIL mid_idle: busy=%0b valid=%0b want 0 0",
               busy, bus.move_valid);
      n_err++;
    end
  endtask

  task automatic test_step_limit();
    corridor();
    bus.move_ready = 1'b1;
    launch(4, 4);
    wait_end("limit");
`ifdef MAZE_SOLVER_STEP_LIMIT_EN
    n_chk++;
    if (fail !== 1'b1 || step_count !== 12'd3
        || pos_x !== 3'd3 || pos_y !== 3'd0) begin
      $display("FAIL limit_fail: fail=%0b step=%0d pos=%0d,%0d want 1 3 3,0",
               fail, step_count, pos_x, pos_y);
      n_err++;
    end
    n_chk++;
    if (moves.size() !== 3) begin
      $display("FAIL limit_nmoves: got %0d want 3", moves.size());
      n_err++;
    end
`else
    n_chk++;
    if (done !== 1'b1 || step_count !== 12'd6 || heading !== 2'd2
        || pos_x !== 3'd3 || pos_y !== 3'd3) begin
      $display("FAIL walk6_end: done=%0b step=%0d hdg=%0d pos=%0d,%0d want 1 6 2 3,3",
               done, step_count, heading, pos_x, pos_y);
      n_err++;
    end
    n_chk++;
    if (moves.size() !== 6) begin
      $display("FAIL walk6_nmoves: got %0d want 6", moves.size());
      n_err++;
    end else begin
      n_chk++;
      if (moves[2] !== 2'd1 || moves[3] !== 2'd2) begin
        $display("FAIL walk6_turn: got %0d,%0d want 1,2",
                 moves[2], moves[3]);
        n_err++;
      end
    end
`endif
  endtask

  initial begin
    bus.move_ready = 1'b0;
    clear_cells();
    test_reset();
    test_one_by_one();
    test_zero_dim();
    test_two_by_one();
    test_two_by_two();
    test_offgrid_fail();
    test_backpressure();
    test_reset_mid();
    test_step_limit();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end
endmodule
